// File: rtl/exe_muldiv_unit.sv
// Iterative unsigned multiply / divide / remainder unit for the EXE stage.
// One operation per accept, WIDTH iterations, result held until the next completion.
//   state | meaning
//   IDLE  | waiting for a MUL/DIV/REM start
//   BUSY  | iterating, pipeline stalled
//   DONE  | one-cycle result / write-back pulse
module exe_muldiv_unit #(
    parameter int         WIDTH   = 32,
    parameter logic [3:0] CMD_MUL = 4'd11,
    parameter logic [3:0] CMD_DIV = 4'd12,
    parameter logic [3:0] CMD_REM = 4'd13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       EXE_CMD,
    input  logic [WIDTH-1:0] val1,
    input  logic [WIDTH-1:0] val2,
    input  logic [4:0]       dest,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       dest_out,
    output logic             WB_EN_out
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [3:0]       cmd_q;
    logic [4:0]       dest_q;
    logic [WIDTH-1:0] opa_q;
    logic [WIDTH-1:0] opb_q;
    logic [WIDTH-1:0] acc_q;
    logic [2*WIDTH:0] rem_q;

    logic             cmd_ok;
    logic             accept;
    logic [WIDTH-1:0] mul_nxt;
    logic [2*WIDTH:0] rem_sh;
    logic [WIDTH:0]   rem_hi;
    logic [WIDTH:0]   rem_diff;
    logic [2*WIDTH:0] rem_nxt;

    assign cmd_ok = (EXE_CMD == CMD_MUL) || (EXE_CMD == CMD_DIV) || (EXE_CMD == CMD_REM);
    assign accept = (state == S_IDLE) && start && cmd_ok && !flush;

    assign stall     = accept || (state == S_BUSY);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign WB_EN_out = done;

    // One step of shift-add multiply and one step of restoring division
    always_comb begin
        mul_nxt  = opb_q[0] ? (acc_q + opa_q) : acc_q;
        rem_sh   = {rem_q[2*WIDTH-1:0], 1'b0};
        rem_hi   = rem_sh[2*WIDTH:WIDTH];
        rem_diff = rem_hi - {1'b0, opb_q};
        rem_nxt  = rem_sh;
        if (rem_hi >= {1'b0, opb_q}) begin
            rem_nxt = {rem_diff, rem_sh[WIDTH-1:1], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            cmd_q    <= '0;
            dest_q   <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            result   <= '0;
            dest_out <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state  <= S_BUSY;
                        cnt    <= '0;
                        cmd_q  <= EXE_CMD;
                        dest_q <= dest;
                        opa_q  <= val1;
                        opb_q  <= val2;
                        acc_q  <= '0;
                        rem_q  <= {{(WIDTH+1){1'b0}}, val1};
                    end
                end
                S_BUSY: begin
                    if (flush) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end else begin
                        if (cmd_q == CMD_MUL) begin
                            acc_q <= mul_nxt;
                            opa_q <= opa_q << 1;
                            opb_q <= opb_q >> 1;
                        end else begin
                            rem_q <= rem_nxt;
                        end
                        if (cnt == CNT_LAST) begin
                            state    <= S_DONE;
                            cnt      <= '0;
                            dest_out <= dest_q;
                            if (cmd_q == CMD_MUL)
                                result <= mul_nxt;
                            else if (cmd_q == CMD_DIV)
                                result <= rem_nxt[WIDTH-1:0];
                            else
                                result <= rem_nxt[2*WIDTH-1:WIDTH];
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                // Flush is ignored here: the completed result still goes downstream
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_exe_muldiv_unit.sv
// Directed self-checking bench for exe_muldiv_unit.
module tb_exe_muldiv_unit;
    localparam logic [3:0] MUL = 4'd11;
    localparam logic [3:0] DIV = 4'd12;
    localparam logic [3:0] REM = 4'd13;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  EXE_CMD = 4'd0;
    logic [31:0] val1 = '0;
    logic [31:0] val2 = '0;
    logic [4:0]  dest = '0;
    logic        flush = 1'b0;
    logic        stall, busy, done, WB_EN_out;
    logic [31:0] result;
    logic [4:0]  dest_out;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    exe_muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .EXE_CMD(EXE_CMD),
        .val1(val1), .val2(val2), .dest(dest), .flush(flush),
        .stall(stall), .busy(busy), .done(done), .result(result),
        .dest_out(dest_out), .WB_EN_out(WB_EN_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Issue one op (caller is just after a rising edge) and run until done or timeout.
    task automatic do_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] d, output int lat, output int stall_cyc,
                         output int done_cyc);
        start = 1'b1; EXE_CMD = c; val1 = a; val2 = b; dest = d;
        lat = -1; stall_cyc = 0; done_cyc = -1;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (stall) stall_cyc++;
            @(posedge clk); #1;
            start = 1'b0; EXE_CMD = 4'd0;
            if (done) begin
                lat = i; done_cyc = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #1;
        total++; if ({stall, busy, done, WB_EN_out} !== 4'b0) begin bad++; $display("FAIL reset_flags got=%b want=0000", {stall, busy, done, WB_EN_out}); end
        total++; if (result !== 32'd0 || dest_out !== 5'd0) begin bad++; $display("FAIL reset_result got=%h/%0d want=0/0", result, dest_out); end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_mul_basic();
        int lat, sc, dc;
        do_op(MUL, 32'd7, 32'd6, 5'd5, lat, sc, dc);
        total++; if (lat !== 33) begin bad++; $display("FAIL mul_latency got=%0d want=33", lat); end
        total++; if (sc !== 33) begin bad++; $display("FAIL mul_stall_cycles got=%0d want=33", sc); end
        total++; if (result !== 32'd42) begin bad++; $display("FAIL mul_result got=%0d want=42", result); end
        total++; if (dest_out !== 5'd5) begin bad++; $display("FAIL mul_dest got=%0d want=5", dest_out); end
        total++; if (WB_EN_out !== 1'b1 || stall !== 1'b0) begin bad++; $display("FAIL mul_wb_stall got=%b%b want=10", WB_EN_out, stall); end
        @(posedge clk); #1;
        total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL mul_done_width got=%b%b want=00", done, busy); end
    endtask

    task automatic test_arith();
        int lat, sc, dc;
        do_op(MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, lat, sc, dc);
        total++; if (result !== 32'h0000_0001) begin bad++; $display("FAIL mul_max got=%h want=00000001", result); end
        @(posedge clk); #1;
        do_op(DIV, 32'd100, 32'd7, 5'd2, lat, sc, dc);
        total++; if (result !== 32'd14) begin bad++; $display("FAIL div_100_7 got=%0d want=14", result); end
        @(posedge clk); #1;
        do_op(REM, 32'd100, 32'd7, 5'd3, lat, sc, dc);
        total++; if (result !== 32'd2) begin bad++; $display("FAIL rem_100_7 got=%0d want=2", result); end
        total++; if (dest_out !== 5'd3) begin bad++; $display("FAIL rem_dest got=%0d want=3", dest_out); end
        @(posedge clk); #1;
    endtask

    task automatic test_div_zero();
        int lat, sc, dc;
        do_op(DIV, 32'h1234, 32'd0, 5'd8, lat, sc, dc);
        total++; if (result !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div0_quot got=%h want=ffffffff", result); end
        total++; if (lat !== 33) begin bad++; $display("FAIL div0_latency got=%0d want=33", lat); end
        @(posedge clk); #1;
        do_op(REM, 32'h1234, 32'd0, 5'd9, lat, sc, dc);
        total++; if (result !== 32'h0000_1234) begin bad++; $display("FAIL rem0 got=%h want=00001234", result); end
        total++; if (lat !== 33) begin bad++; $display("FAIL rem0_latency got=%0d want=33", lat); end
        @(posedge clk); #1;
    endtask

    task automatic test_flush();
        int seen_done = 0;
        start = 1'b1; EXE_CMD = DIV; val1 = 32'd500; val2 = 32'd3; dest = 5'd20;
        @(posedge clk); #1;
        start = 1'b0; EXE_CMD = 4'd0;
        repeat (4) @(posedge clk);
        #1 flush = 1'b1;
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL flush_stall_hold got=%b want=1", stall); end
        @(posedge clk); #1;
        flush = 1'b0;
        #1;
        total++; if (stall !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL flush_idle got=%b%b want=00", stall, busy); end
        repeat (40) begin
            @(posedge clk); #1;
            if (done) seen_done++;
        end
        total++; if (seen_done !== 0) begin bad++; $display("FAIL flush_no_done got=%0d want=0", seen_done); end
        total++; if (result !== 32'h1234 || dest_out !== 5'd9) begin bad++; $display("FAIL flush_result_kept got=%h/%0d want=00001234/9", result, dest_out); end
        start = 1'b1; EXE_CMD = MUL; val1 = 32'd2; val2 = 32'd2; flush = 1'b1;
        @(negedge clk);
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL start_flush_stall got=%b want=0", stall); end
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0; EXE_CMD = 4'd0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL start_flush_busy got=%b want=0", busy); end
    endtask

    task automatic test_reset_mid_busy();
        int lat, sc, dc;
        start = 1'b1; EXE_CMD = DIV; val1 = 32'd100; val2 = 32'd7; dest = 5'd11;
        @(posedge clk); #1;
        start = 1'b0; EXE_CMD = 4'd0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        total++; if ({stall, busy, done} !== 3'b0) begin bad++; $display("FAIL rst_mid_flags got=%b want=000", {stall, busy, done}); end
        total++; if (result !== 32'd0) begin bad++; $display("FAIL rst_mid_result got=%h want=0", result); end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        do_op(MUL, 32'd9, 32'd9, 5'd4, lat, sc, dc);
        total++; if (result !== 32'd81 || lat !== 33) begin bad++; $display("FAIL rst_recover got=%0d lat=%0d want=81 lat=33", result, lat); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int lat, sc, dc1, dc2;
        do_op(MUL, 32'd3, 32'd4, 5'd6, lat, sc, dc1);
        total++; if (result !== 32'd12) begin bad++; $display("FAIL b2b_first got=%0d want=12", result); end
        @(posedge clk); #1;
        do_op(MUL, 32'd5, 32'd5, 5'd7, lat, sc, dc2);
        total++; if (result !== 32'd25) begin bad++; $display("FAIL b2b_second got=%0d want=25", result); end
        total++; if (dc2 - dc1 !== 34) begin bad++; $display("FAIL b2b_interval got=%0d want=34", dc2 - dc1); end
        @(posedge clk); #1;
    endtask

    task automatic test_ignored_cmd();
        start = 1'b1; EXE_CMD = 4'd0; val1 = 32'd1; val2 = 32'd1;
        @(negedge clk);
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL bad_cmd_stall got=%b want=0", stall); end
        @(posedge clk); #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL bad_cmd_busy got=%b want=0", busy); end
        start = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_mul_basic();
        test_arith();
        test_div_zero();
        test_flush();
        test_reset_mid_busy();
        test_back_to_back();
        test_ignored_cmd();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
